// File: rtl/peso_kg_conversor_pkg.sv
// Constants and types shared by the weighing front-end and the display stage.
package peso_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int TARA_DEFAULT_G = 40;
  localparam int DIVISOR_G      = 1000;

endpackage

// File: rtl/peso_kg_conversor_if.sv
// Sample-in / result-out handshake bundle of the grams-to-kg converter, plus tare loading.
interface peso_kg_conversor_if #(
  parameter int W       = 16,
  parameter int DIVISOR = peso_pkg::DIVISOR_G
);
  localparam int RW = $clog2(DIVISOR);

  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  gramas;
  logic          tare_capture;
  logic          tare_load;
  logic [W-1:0]  tare_value;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  peso_kg;
  logic [RW-1:0] peso_g;
  logic          underflow;

  modport master (
    output in_valid, gramas, tare_capture, tare_load, tare_value, out_ready,
    input  in_ready, out_valid, peso_kg, peso_g, underflow
  );

  modport slave (
    input  in_valid, gramas, tare_capture, tare_load, tare_value, out_ready,
    output in_ready, out_valid, peso_kg, peso_g, underflow
  );

endinterface

// File: rtl/seq_divider_restoring.sv
// Restoring divider by a constant: one quotient bit per cycle, MSB first, W cycles per division.
module seq_divider_restoring
  import peso_pkg::*;
#(
  parameter int W       = 16,
  parameter int DIVISOR = DIVISOR_G,
  localparam int RW     = $clog2(DIVISOR)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_i,
  input  logic [W-1:0]  dividend_i,
  output logic          busy_o,
  output logic          done_o,
  output logic [W-1:0]  quotient_o,
  output logic [RW-1:0] remainder_o
);

  localparam int         CW    = (W > 1) ? $clog2(W) : 1;
  localparam logic [RW:0] DIV_C = (RW+1)'(DIVISOR);

  // Dividend bits shift out of the top of quo_q while quotient bits shift in at the bottom.
  logic [W-1:0]  quo_q, quo_d;
  logic [RW:0]   rem_q, rem_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [RW:0]   trial;

  always_comb begin
    // NOTE: every variable assigned here gets a default first, so no latch is inferred.
    quo_d  = quo_q;
    rem_d  = rem_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;
    trial  = (rem_q << 1) | (RW+1)'(quo_q[W-1]);

    if (start_i && !busy_q) begin
      quo_d  = dividend_i;
      rem_d  = '0;
      cnt_d  = CW'(W - 1);
      busy_d = 1'b1;
    end else if (busy_q) begin
      if (trial >= DIV_C) begin
        rem_d = trial - DIV_C;
        quo_d = {quo_q[W-2:0], 1'b1};
      end else begin
        rem_d = trial;
        quo_d = {quo_q[W-2:0], 1'b0};
      end
      if (cnt_q == '0) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      quo_q  <= '0;
      rem_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      quo_q  <= quo_d;
      rem_q  <= rem_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign quotient_o  = quo_q;
  assign remainder_o = rem_q[RW-1:0];

endmodule

// File: rtl/peso_kg_conversor.sv
// Weighing front-end: tare subtraction with underflow clamp, then sequential split into kg and g.
module peso_kg_conversor
  import peso_pkg::*;
#(
  parameter int W            = 16,
  parameter int DIVISOR      = DIVISOR_G,
  parameter int TARA_DEFAULT = TARA_DEFAULT_G,
  localparam int RW          = $clog2(DIVISOR)
) (
  input  logic                  clk,
  input  logic                  rst,
  peso_kg_conversor_if.slave    bus
);

  if (DIVISOR < 2 || longint'(DIVISOR) > ((longint'(1) << W) - 1)) begin : g_bad_divisor
    $error("peso_kg_conversor: DIVISOR must lie in [2, 2**W-1]");
  end

  state_e        state_q, state_d;
  logic          in_ready_q, in_ready_d;
  logic          out_valid_q, out_valid_d;
  logic [W-1:0]  kg_q, kg_d;
  logic [RW-1:0] g_q, g_d;
  logic          uf_q, uf_d;
  logic [W-1:0]  tara_q, tara_d;

  logic          accept;
  logic [W-1:0]  tara_eff;
  logic          below;
  logic [W-1:0]  net;
  logic          div_busy;
  logic          div_done;
  logic [W-1:0]  div_quo;
  logic [RW-1:0] div_rem;

  // A capturing sample is its own tare, so its net is always zero.
  assign accept   = bus.in_valid && (state_q == IDLE);
  assign tara_eff = bus.tare_capture ? bus.gramas : tara_q;
  assign below    = bus.gramas < tara_eff;
  assign net      = below ? '0 : bus.gramas - tara_eff;

  seq_divider_restoring #(
    .W       (W),
    .DIVISOR (DIVISOR)
  ) u_div (
    .clk         (clk),
    .rst         (rst),
    .start_i     (accept),
    .dividend_i  (net),
    .busy_o      (div_busy),
    .done_o      (div_done),
    .quotient_o  (div_quo),
    .remainder_o (div_rem)
  );

  always_comb begin
    state_d     = state_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    kg_d        = kg_q;
    g_d         = g_q;
    uf_d        = uf_q;
    tara_d      = tara_q;

    case (state_q)
      IDLE: if (accept) begin
        state_d    = DIV;
        in_ready_d = 1'b0;
        uf_d       = below;
      end
      DIV: if (div_done && !div_busy) begin
        state_d     = DONE;
        out_valid_d = 1'b1;
        kg_d        = div_quo;
        g_d         = div_rem;
      end
      DONE: if (bus.out_ready) begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // An explicit load overrides a capture on the same edge.
    if (bus.tare_load) begin
      tara_d = bus.tare_value;
    end else if (accept && bus.tare_capture) begin
      tara_d = bus.gramas;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      kg_q        <= '0;
      g_q         <= '0;
      uf_q        <= 1'b0;
      tara_q      <= W'(TARA_DEFAULT);
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      kg_q        <= kg_d;
      g_q         <= g_d;
      uf_q        <= uf_d;
      tara_q      <= tara_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.peso_kg   = kg_q;
  assign bus.peso_g    = g_q;
  assign bus.underflow = uf_q;

endmodule

// File: tb/tb_peso_kg_conversor.sv
// Directed bench: stimulus pushes expected results into a scoreboard, a negedge monitor pops and compares.
module tb_peso_kg_conversor;
  import peso_pkg::*;

  localparam int W       = 16;
  localparam int DIVISOR = DIVISOR_G;
  localparam int RW      = $clog2(DIVISOR);

  typedef struct packed {
    logic [W-1:0]  kg;
    logic [RW-1:0] g;
    logic          uf;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  peso_kg_conversor_if #(.W(W), .DIVISOR(DIVISOR)) bus ();

  peso_kg_conversor #(
    .W            (W),
    .DIVISOR      (DIVISOR),
    .TARA_DEFAULT (TARA_DEFAULT_G)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t sb[$];
  exp_t mon_e;
  int   n_vec   = 0;
  int   n_err   = 0;
  int   cyc     = 0;
  int   acc_cyc = 0;
  logic ov_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input int kg, input int g, input bit uf);
    exp_t e;
    e.kg = W'(kg);
    e.g  = RW'(g);
    e.uf = uf;
    return e;
  endfunction

  // Monitor: latency of each out_valid rise, and result contents on every completed handshake.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.out_valid && !ov_prev) check("latency", 64'(cyc - acc_cyc), 64'(W + 1));
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected result", 64'd1, 64'd0);
        end else begin
          mon_e = sb.pop_front();
          check("peso_kg",   64'(bus.peso_kg),   64'(mon_e.kg));
          check("peso_g",    64'(bus.peso_g),    64'(mon_e.g));
          check("underflow", 64'(bus.underflow), 64'(mon_e.uf));
        end
      end
    end
    ov_prev = bus.out_valid;
  end

  task automatic send(input logic [W-1:0] g, input logic cap, input logic ld,
                      input logic [W-1:0] lv, input bit expect_it, input exp_t e);
    bit ok;
    ok = 1'b0;
    if (expect_it) sb.push_back(e);
    @(negedge clk);
    bus.in_valid     = 1'b1;
    bus.gramas       = g;
    bus.tare_capture = cap;
    bus.tare_load    = ld;
    bus.tare_value   = lv;
    repeat (200) begin
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) check("accept timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1 acc_cyc = cyc;
    @(negedge clk);
    bus.in_valid     = 1'b0;
    bus.tare_capture = 1'b0;
    bus.tare_load    = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
    check("scoreboard drained", 64'(sb.size()), 64'd0);
  endtask

  task automatic load_tare(input logic [W-1:0] v);
    @(negedge clk);
    bus.tare_load  = 1'b1;
    bus.tare_value = v;
    @(negedge clk);
    bus.tare_load  = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst              = 1'b1;
    bus.in_valid     = 1'b0;
    bus.gramas       = '0;
    bus.tare_capture = 1'b0;
    bus.tare_load    = 1'b0;
    bus.tare_value   = '0;
    bus.out_ready    = 1'b1;
    repeat (2) @(negedge clk);
    check("reset in_ready",  64'(bus.in_ready),  64'd1);
    check("reset out_valid", 64'(bus.out_valid), 64'd0);
    check("reset peso_kg",   64'(bus.peso_kg),   64'd0);
    check("reset peso_g",    64'(bus.peso_g),    64'd0);
    check("reset underflow", 64'(bus.underflow), 64'd0);
    rst = 1'b0;

    // Default tare of 40 g.
    send(16'd1040,  1'b0, 1'b0, '0, 1'b1, mk(1, 0, 0));    drain();
    send(16'd40,    1'b0, 1'b0, '0, 1'b1, mk(0, 0, 0));    drain();
    send(16'd12345, 1'b0, 1'b0, '0, 1'b1, mk(12, 305, 0)); drain();
    send(16'd65535, 1'b0, 1'b0, '0, 1'b1, mk(65, 495, 0)); drain();
    send(16'd30,    1'b0, 1'b0, '0, 1'b1, mk(0, 0, 1));    drain();
    send(16'd0,     1'b0, 1'b0, '0, 1'b1, mk(0, 0, 1));    drain();

    // Loaded tare, then one-shot capture.
    load_tare(16'd500);
    send(16'd2500, 1'b0, 1'b0, '0, 1'b1, mk(2, 0, 0));   drain();
    send(16'd3000, 1'b1, 1'b0, '0, 1'b1, mk(0, 0, 0));   drain();
    send(16'd4250, 1'b0, 1'b0, '0, 1'b1, mk(1, 250, 0)); drain();

    // Backpressure: 9999 - 3000 = 6999 -> 6 kg 999 g, held while out_ready is low.
    bus.out_ready = 1'b0;
    send(16'd9999, 1'b0, 1'b0, '0, 1'b1, mk(6, 999, 0));
    for (int i = 0; i < 100 && !bus.out_valid; i++) @(negedge clk);
    check("bp out_valid rise", 64'(bus.out_valid), 64'd1);
    for (int i = 0; i < 10; i++) begin
      check("bp out_valid", 64'(bus.out_valid), 64'd1);
      check("bp in_ready",  64'(bus.in_ready),  64'd0);
      check("bp peso_kg",   64'(bus.peso_kg),   64'd6);
      check("bp peso_g",    64'(bus.peso_g),    64'd999);
      bus.in_valid = (i == 3);
      bus.gramas   = 16'd1234;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    @(posedge clk);
    #2 bus.out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp release in_ready",  64'(bus.in_ready),  64'd1);
    check("bp release out_valid", 64'(bus.out_valid), 64'd0);
    drain();
    repeat (W + 4) @(negedge clk);
    check("ignored pulse no result", 64'(bus.out_valid), 64'd0);

    // Load and capture on the same edge: load wins, next sample sees tare 100.
    send(16'd5000, 1'b1, 1'b1, 16'd100, 1'b1, mk(0, 0, 0)); drain();
    send(16'd1100, 1'b0, 1'b0, '0,      1'b1, mk(1, 0, 0)); drain();

    // Reset during DIV cycle 5: result discarded, tare back to 40.
    send(16'd5000, 1'b0, 1'b0, '0, 1'b0, mk(0, 0, 0));
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid-div reset out_valid", 64'(bus.out_valid), 64'd0);
    check("mid-div reset in_ready",  64'(bus.in_ready),  64'd1);
    rst = 1'b0;
    send(16'd2040, 1'b0, 1'b0, '0, 1'b1, mk(2, 0, 0)); drain();
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
